mmio_port_responder: RTL and testbench



---
 rtl/mmio_port_pkg.sv | 36 +++
 rtl/io_change_fifo.sv | 68 ++++++
 rtl/mmio_port_responder.sv | 129 ++++++++++++
 tb/tb_mmio_port_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_port_pkg.sv
// Shared constants for the MMIO port responder.
// Holds the word offsets (Address[4:2]) of the register window, the bit layout of the
// STATUS register and the CTRL register. It also holds a helper that packs STATUS.
package mmio_port_pkg;

  // Word offsets within the 32-byte window
  localparam logic [2:0] OFS_PORT_OUT  = 3'd0;
  localparam logic [2:0] OFS_PORT_IN   = 3'd1;
  localparam logic [2:0] OFS_FIFO_DATA = 3'd2;
  localparam logic [2:0] OFS_STATUS    = 3'd3;
  localparam logic [2:0] OFS_CTRL      = 3'd4;

  // STATUS bit positions; count occupies [ST_COUNT_LSB +: 4]
  localparam int unsigned ST_EMPTY     = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVF       = 2;
  localparam int unsigned ST_COUNT_LSB = 4;

  // CTRL bit positions
  localparam int unsigned CTRL_CAPTURE_EN = 0;

  // Build the STATUS word from its fields; unused bits read zero.
  function automatic logic [31:0] pack_status(input logic       empty,
                                              input logic       full,
                                              input logic       ovf,
                                              input logic [3:0] count);
    logic [31:0] s;
    s                        = '0;
    s[ST_EMPTY]              = empty;
    s[ST_FULL]               = full;
    s[ST_OVF]                = ovf;
    s[ST_COUNT_LSB +: 4]     = count;
    return s;
  endfunction

endpackage

// File: rtl/io_change_fifo.sv
// Small synchronous FIFO that buffers PortIn change values.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset (clears pointers/count only)
//   push_i, din_i       write request and data
//   pop_i, dout_o       read request; dout_o shows the head entry (undefined when empty)
//   count_o             number of stored entries
//   full_o, empty_o     occupancy flags
//   overflow_pulse_o    one-cycle pulse when a push is dropped because the FIFO is full
module io_change_fifo #(
  parameter int unsigned Width  = 8,
  parameter int unsigned Depth  = 4,
  localparam int unsigned PtrW   = $clog2(Depth),
  localparam int unsigned CountW = PtrW + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [Width-1:0]  din_i,
  output logic [Width-1:0]  dout_o,
  output logic [CountW-1:0] count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              overflow_pulse_o
);

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CountW'(Depth));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A pop from an empty FIFO is ignored. A push into a full FIFO still succeeds
  // when a pop frees the head slot in the same cycle.
  always_comb begin
    do_pop           = pop_i & ~empty_o;
    do_push          = push_i & (~full_o | do_pop);
    overflow_pulse_o = push_i & ~do_push;
    rd_ptr_d         = do_pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    wr_ptr_d         = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    count_d          = count_q + CountW'(do_push) - CountW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers are cleared.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O responder on the data-memory bus.
// Decodes a 32-byte window at BASE_ADDR, drives PortOut from a writable register,
// synchronizes PortIn and queues every observed change in a small FIFO that software
// drains with loads from FIFO_DATA.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   Address, WriteData    bus address and store data
//   MemWrite, MemRead     store / load strobes
//   ReadData, Hit         combinational load data and window-hit flag
//   PortIn                asynchronous 8-bit external input
//   PortOut               output register
module mmio_port_responder
  import mmio_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut
);

  localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       port_out_q, port_out_d;
  logic              capture_en_q, capture_en_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        q1_q, q2_q, q3_q;

  logic [2:0]        ofs;
  logic              wr_en, rd_en;
  logic              change, pop;
  logic [7:0]        fifo_dout;
  logic [CountW-1:0] fifo_count;
  logic              fifo_full, fifo_empty, fifo_ovf_pulse;
  logic [3:0]        count_field;

  // Byte lane select is irrelevant for these word registers.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^Address[1:0];

  assign Hit     = (Address[31:5] == BASE_ADDR[31:5]);
  assign ofs     = Address[4:2];
  assign wr_en   = Hit & MemWrite;
  assign rd_en   = Hit & MemRead;
  assign PortOut = port_out_q;

  // q3 follows q2 even while capture is off so enabling capture cannot see a stale edge.
  assign change = capture_en_q & (q2_q != q3_q);
  assign pop    = rd_en & (ofs == OFS_FIFO_DATA);

  io_change_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i            (clk),
    .rst_i            (reset),
    .push_i           (change),
    .pop_i            (pop),
    .din_i            (q2_q),
    .dout_o           (fifo_dout),
    .count_o          (fifo_count),
    .full_o           (fifo_full),
    .empty_o          (fifo_empty),
    .overflow_pulse_o (fifo_ovf_pulse)
  );

  // The STATUS count field is 4 bits wide whatever the FIFO depth.
  assign count_field = 4'(fifo_count);

  always_comb begin
    port_out_d   = port_out_q;
    capture_en_d = capture_en_q;
    overflow_d   = overflow_q;
    if (wr_en && ofs == OFS_PORT_OUT) begin
      port_out_d = WriteData;
    end
    if (wr_en && ofs == OFS_CTRL) begin
      capture_en_d = WriteData[CTRL_CAPTURE_EN];
    end
    if (wr_en && ofs == OFS_STATUS && WriteData[ST_OVF]) begin
      overflow_d = 1'b0;
    end
    // A dropped push in the same cycle as a clear keeps the flag set.
    if (fifo_ovf_pulse) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      port_out_q   <= '0;
      capture_en_q <= 1'b0;
      overflow_q   <= 1'b0;
      q1_q         <= '0;
      q2_q         <= '0;
      q3_q         <= '0;
    end else begin
      port_out_q   <= port_out_d;
      capture_en_q <= capture_en_d;
      overflow_q   <= overflow_d;
      q1_q         <= PortIn;
      q2_q         <= q1_q;
      q3_q         <= q2_q;
    end
  end

  always_comb begin
    ReadData = '0;
    if (Hit) begin
      case (ofs)
        OFS_PORT_OUT:  ReadData = port_out_q;
        OFS_PORT_IN:   ReadData = {24'b0, q2_q};
        OFS_FIFO_DATA: ReadData = fifo_empty ? 32'b0 : {24'b0, fifo_dout};
        OFS_STATUS:    ReadData = pack_status(fifo_empty, fifo_full, overflow_q, count_field);
        OFS_CTRL:      ReadData = {31'b0, capture_en_q};
        default:       ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_port_responder.sv
module tb_mmio_port_responder;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address, WriteData;
  logic        MemWrite, MemRead;
  logic [31:0] ReadData;
  logic        Hit;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;

  always #5 clk = ~clk;

  mmio_port_responder #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .ReadData  (ReadData),
    .Hit       (Hit),
    .PortIn    (PortIn),
    .PortOut   (PortOut)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: the change queue plus the last three PortIn samples taken at edges.
  logic [7:0]  mq[$];
  logic        m_ovf, m_cap, m_valid;
  logic [31:0] m_pout;
  logic [7:0]  smp[3];   // smp[0] newest edge sample, smp[1] is what software sees on PORT_IN
  logic [31:0] last_rd;
  logic        last_hit;
  logic [7:0]  pin_cur;

  initial m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [31:0] r;
    int          cnt;
    r   = 0;
    cnt = mq.size();
    if (a[31:5] == BASE[31:5]) begin
      case (a[4:2])
        3'd0: r = m_pout;
        3'd1: r = {24'b0, smp[1]};
        3'd2: r = (cnt > 0) ? {24'b0, mq[0]} : 32'b0;
        3'd3: r = (cnt * 16) + ((m_ovf ? 1 : 0) * 4) + ((cnt == DEPTH) ? 2 : 0) + ((cnt == 0) ? 1 : 0);
        3'd4: r = {31'b0, m_cap};
        default: r = 0;
      endcase
    end
    return r;
  endfunction

  task automatic model_step(input logic [31:0] a, input logic [31:0] wd, input logic mw,
                            input logic mr, input logic [7:0] pin, input logic rst);
    logic hit, wr, rd, changed, drop;
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_cap = 0; m_pout = 0;
      smp[0] = 0; smp[1] = 0; smp[2] = 0;
      m_valid = 1'b1;
      return;
    end
    hit     = (a[31:5] == BASE[31:5]);
    wr      = hit & mw;
    rd      = hit & mr;
    changed = m_cap && (smp[1] != smp[2]);
    drop    = 1'b0;
    if (rd && a[4:2] == 3'd2 && mq.size() > 0) void'(mq.pop_front());
    if (changed) begin
      if (mq.size() < DEPTH) mq.push_back(smp[1]);
      else drop = 1'b1;
    end
    if (wr && a[4:2] == 3'd3 && wd[2]) m_ovf = 0;
    if (drop) m_ovf = 1;
    if (wr && a[4:2] == 3'd0) m_pout = wd;
    if (wr && a[4:2] == 3'd4) m_cap = wd[0];
    smp[2] = smp[1]; smp[1] = smp[0]; smp[0] = pin;
  endtask

  // One bus cycle: drive, compare combinational outputs mid-cycle, advance model and clock.
  task automatic cyc(input logic [31:0] a, input logic [31:0] wd, input logic mw,
                     input logic mr, input logic rst);
    Address = a; WriteData = wd; MemWrite = mw; MemRead = mr; PortIn = pin_cur; reset = rst;
    #4;
    last_rd  = ReadData;
    last_hit = Hit;
    if (m_valid) begin
      check("ReadData", ReadData, model_rd(a));
      check("Hit", {31'b0, Hit}, {31'b0, (a[31:5] == BASE[31:5])});
      check("PortOut", PortOut, m_pout);
    end
    model_step(a, wd, mw, mr, pin_cur, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(BASE + 32'h18, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic st(input logic [31:0] ofs, input logic [31:0] d);
    cyc(BASE + ofs, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic ld(input logic [31:0] ofs);
    cyc(BASE + ofs, 32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    pin_cur = v;
    idle(n);
  endtask

  initial begin
    pin_cur = 8'h00;
    Address = 0; WriteData = 0; MemWrite = 0; MemRead = 0; PortIn = 0; reset = 1;

    // 1: reset, PORT_OUT store, STATUS after reset
    cyc(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    st(32'h00, 32'h0000_00A5);
    check("t1_portout", PortOut, 32'h0000_00A5);
    ld(32'h0C);
    check("t1_status", last_rd, 32'h01);

    // 2: single change captured and popped
    st(32'h10, 32'h1);
    hold(8'h3C, 3);
    ld(32'h0C);
    check("t2_status_one", last_rd, 32'h10);
    ld(32'h08);
    check("t2_pop", last_rd, 32'h3C);
    ld(32'h0C);
    check("t2_status_empty", last_rd, 32'h01);

    // 3: five changes into a four-deep FIFO
    for (int v = 1; v <= 5; v++) hold(8'(v), 3);
    idle(2);
    ld(32'h0C);
    check("t3_status_full_ovf", last_rd, 32'h46);
    for (int v = 1; v <= 4; v++) begin
      ld(32'h08);
      check("t3_pop", last_rd, 32'(v));
    end
    ld(32'h08);
    check("t3_pop_empty", last_rd, 32'h0);

    // 4: push and pop on the same edge while full
    st(32'h0C, 32'h4);
    for (int v = 8'h11; v <= 8'h14; v++) hold(8'(v), 3);
    idle(2);
    ld(32'h0C);
    check("t4_status_full", last_rd, 32'h42);
    hold(8'h15, 2);
    ld(32'h08);
    check("t4_pop_head", last_rd, 32'h11);
    ld(32'h0C);
    check("t4_status_after", last_rd, 32'h42);
    for (int v = 8'h12; v <= 8'h15; v++) begin
      ld(32'h08);
      check("t4_drain", last_rd, 32'(v));
    end

    // 5: changes while capture is off are not queued, even after re-enabling
    st(32'h10, 32'h0);
    hold(8'h00, 4);
    hold(8'hFF, 4);
    st(32'h10, 32'h1);
    idle(4);
    ld(32'h0C);
    check("t5_status", last_rd, 32'h01);
    ld(32'h04);
    check("t5_port_in", last_rd, 32'hFF);

    // 6: reset with two entries queued, then window edges
    hold(8'h21, 3);
    hold(8'h22, 3);
    idle(2);
    ld(32'h0C);
    check("t6_status_two", last_rd, 32'h20);
    cyc(BASE, 32'h0, 1'b0, 1'b0, 1'b1);
    ld(32'h0C);
    check("t6_status_reset", last_rd, 32'h01);
    check("t6_portout_reset", PortOut, 32'h0);
    ld(32'h10);
    check("t6_ctrl_reset", last_rd, 32'h0);
    ld(32'h14);
    check("t6_unmapped_rd", last_rd, 32'h0);
    check("t6_unmapped_hit", {31'b0, last_hit}, 32'h1);
    cyc(BASE + 32'h20, 32'h0, 1'b0, 1'b1, 1'b0);
    check("t6_miss_hit", {31'b0, last_hit}, 32'h0);
    check("t6_miss_rd", last_rd, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] a, wd;
      int          sel;
      sel = int'($urandom_range(0, 15));
      if (sel == 0)      a = $urandom();
      else if (sel == 1) a = BASE + 32'h20 + ($urandom() & 32'hFF);
      else if (sel == 2) a = BASE - 32'h4;
      else               a = BASE + {27'b0, 3'($urandom_range(0, 7)), 2'($urandom())};
      wd = $urandom();
      if ($urandom_range(0, 9) < 3) pin_cur = 8'($urandom_range(0, 3) * 8'h41);
      cyc(a, wd, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) < 2),
          ($urandom_range(0, 299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
